bram_access_arbiter: RTL and testbench

Round-robin arbiter that shares one `dual_port_block_ram` instance between NUM_REQ requesters in the particle filter, such as the particle update, weight normalisation and resampling engines. It issues at most one RAM access per cycle, either a read or a write. It drives the RAM write and read ports from the granted request and returns read data with a per-requester valid strobe. Both RAM clocks are tied to the arbiter clock.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/bram_access_arbiter.sv | 108 ++++++++++
 tb/tb_bram_access_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM access arbiter.
// Contents: maximum requester count, a clog2 pointer-width helper and
// slice-index helpers for the flattened per-requester address/data buses.
package bram_arb_pkg;

  localparam int unsigned MaxNumReq = 8;

  // Bits needed to hold an index in 0..n-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of slice idx in a bus of width-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick.
// Ports:
//   req     - request vector
//   last    - index of the most recently granted requester
//   win     - one-hot winner (zero when nothing is requested)
//   win_idx - index of the winner (0 when nothing is requested)
//   win_any - at least one request is asserted
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_any
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    win_any = 1'b0;
    // Search last+1, last+2, ... wrapping; last itself is checked last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last) + off) % NUM_REQ;
      if (!win_any && req[idx]) begin
        win_any  = 1'b1;
        win_idx  = PTR_W'(idx);
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter sharing one dual-port block RAM between NUM_REQ
// requesters, one access (read or write) per cycle.
// Ports:
//   clk, rst          - clock (also the RAM clocks) and synchronous active-high reset
//   req/req_we/req_lock, req_addr/req_wdata - per-requester request fields (flattened)
//   gnt               - combinational one-hot grant
//   rvalid, rdata     - registered one-hot read-valid, read data from the RAM
//   ram_*             - RAM port drive; ram_dout is the RAM output register
module bram_access_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  output logic                          ram_write_en,
  output logic                          ram_read_en,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  localparam int unsigned PtrW = clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  logic [PtrW-1:0]    last_q, last_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0] pick_win;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;

  logic               lock_hit;
  logic               grant_any;
  logic [PtrW-1:0]    gnt_idx;
  logic               gnt_we;
  logic [PtrW-1:0]    sel_idx;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

  always_comb begin
    // A locked previous grant keeps priority only while it is still requesting.
    lock_hit  = lock_q & req[last_q];
    grant_any = ~rst & (lock_hit | pick_any);
    gnt_idx   = lock_hit ? last_q : pick_idx;
    gnt_we    = req_we[gnt_idx];
    gnt       = grant_any ? (OneHot0 << gnt_idx) : '0;

    last_d   = grant_any ? gnt_idx : last_q;
    lock_d   = grant_any ? req_lock[gnt_idx] : lock_q;
    rvalid_d = (grant_any && !gnt_we) ? gnt : '0;

    ram_write_en = grant_any & gnt_we;
    ram_read_en  = grant_any & ~gnt_we;
  end

  // Idle cycles drive requester 0's slices onto the RAM port.
  always_comb begin
    sel_idx   = grant_any ? gnt_idx : '0;
    ram_din   = req_wdata[DATA_WIDTH-1:0];
    ram_waddr = req_addr[ADDR_WIDTH-1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PtrW'(i)) begin
        ram_din   = req_wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        ram_waddr = req_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
      end
    end
    ram_raddr = ram_waddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= PtrW'(NUM_REQ - 1);
      lock_q   <= 1'b0;
      rvalid_q <= '0;
    end else begin
      last_q   <= last_d;
      lock_q   <= lock_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Masking with rst drops the return of a read granted just before reset.
  assign rvalid = rst ? '0 : rvalid_q;
  assign rdata  = ram_dout;

endmodule

// File: tb/tb_bram_access_arbiter.sv
module tb_bram_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic            ram_write_en, ram_read_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } rv_t;
  rv_t sb[$];

  always #5 clk = ~clk;

  bram_access_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .ram_din      (ram_din),
    .ram_waddr    (ram_waddr),
    .ram_raddr    (ram_raddr),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_dout     (ram_dout)
  );

  // Initial RAM image: address 5 preloaded with 0x1234.
  function automatic logic [15:0] init_word(input logic [AW-1:0] a);
    if (a == 10'h005) return 16'h1234;
    return {6'h0, a} ^ 16'hA5A5;
  endfunction

  // RAM model: registered read port, write port, same clock.
  logic [15:0] ram_mem [1024];
  logic        ram_wr  [1024];
  always @(posedge clk) begin
    if (ram_write_en) begin
      ram_mem[ram_waddr] <= ram_din;
      ram_wr[ram_waddr]  <= 1'b1;
    end
    if (ram_read_en) begin
      ram_dout <= (ram_wr[ram_raddr] === 1'b1) ? ram_mem[ram_raddr] : init_word(ram_raddr);
    end
  end

  // Reference memory tracked from the stimulus.
  logic [15:0] ref_mem [1024];
  logic        ref_wr  [1024];

  function automatic logic [15:0] ref_read(input logic [AW-1:0] a);
    return (ref_wr[a] === 1'b1) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_lock[i]           = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    req[i]      = 1'b0;
    req_lock[i] = 1'b0;
  endtask

  // One cycle: check the expected grant (-1 = none) and the scheduled read return.
  task automatic tick(input int eg);
    rv_t         e;
    logic [AW-1:0] a;
    @(negedge clk);
    e = '{idx: -1, data: 16'h0};
    if (sb.size() > 0) e = sb.pop_front();
    if (rst) e.idx = -1;
    chk("rvalid", 32'(rvalid), 32'(onehot(e.idx)));
    if (e.idx >= 0) chk("rdata", 32'(rdata), 32'(e.data));
    chk("gnt", 32'(gnt), 32'(onehot(eg)));
    if (eg >= 0) begin
      a = req_addr[eg*AW +: AW];
      if (req_we[eg]) begin
        chk("wen", 32'(ram_write_en), 32'd1);
        chk("ren", 32'(ram_read_en), 32'd0);
        chk("waddr", 32'(ram_waddr), 32'(a));
        chk("din", 32'(ram_din), 32'(req_wdata[eg*DW +: DW]));
        ref_mem[a] = req_wdata[eg*DW +: DW];
        ref_wr[a]  = 1'b1;
        sb.push_back('{idx: -1, data: 16'h0});
      end else begin
        chk("ren", 32'(ram_read_en), 32'd1);
        chk("wen", 32'(ram_write_en), 32'd0);
        chk("raddr", 32'(ram_raddr), 32'(a));
        sb.push_back('{idx: eg, data: ref_read(a)});
      end
    end else begin
      chk("wen_idle", 32'(ram_write_en), 32'd0);
      chk("ren_idle", 32'(ram_read_en), 32'd0);
      sb.push_back('{idx: -1, data: 16'h0});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '1;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset holds off grants even with all requesters asserted.
    tick(-1);
    rst = 1'b0;
    req = '0;

    // Single read of preloaded address 5.
    set_req(2, 1'b0, 1'b0, 10'h005, 16'h0);
    tick(2);
    clr_req(2);
    tick(-1);

    // Write top address, read it back next cycle.
    set_req(1, 1'b1, 1'b0, 10'h3FF, 16'hBEEF);
    tick(1);
    clr_req(1);
    set_req(3, 1'b0, 1'b0, 10'h3FF, 16'h0);
    tick(3);
    clr_req(3);
    tick(-1);

    // Fairness after reset: all four reading continuously.
    rst = 1'b1;
    tick(-1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(10'h100 + i), 16'h0);
    for (int k = 0; k < 8; k++) tick(k % N);
    req = '0;
    tick(-1);

    // Lock burst on requester 1 while 0 and 2 wait.
    set_req(0, 1'b0, 1'b0, 10'h020, 16'h0);
    tick(0);
    set_req(1, 1'b1, 1'b1, 10'h040, 16'h1111);
    set_req(2, 1'b0, 1'b0, 10'h041, 16'h0);
    tick(1);
    set_req(1, 1'b1, 1'b1, 10'h042, 16'h2222);
    tick(1);
    set_req(1, 1'b0, 1'b1, 10'h040, 16'h0);
    tick(1);
    clr_req(1);
    tick(2);
    clr_req(2);
    tick(0);
    req = '0;
    tick(-1);

    // Reset right after a read grant suppresses its return.
    set_req(0, 1'b0, 1'b0, 10'h005, 16'h0);
    tick(0);
    rst = 1'b1;
    set_req(3, 1'b0, 1'b0, 10'h042, 16'h0);
    tick(-1);
    rst = 1'b0;
    tick(0);
    clr_req(0);
    tick(3);
    req = '0;

    // Idle: nothing moves, pointer stays at 3.
    for (int k = 0; k < 5; k++) tick(-1);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(10'h3F0 + i), 16'h0);
    tick(0);
    req = '0;
    tick(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
